// File: rtl/chess_pkg.sv
// Shared chess types: square encoding, piece codes, response codes, FSM states
// and the initial-position generator used by the board, move generator and renderer.
package chess_pkg;

  localparam int SQ_W     = 5;
  localparam int N_SQ     = 64;
  localparam int BOARD_W  = N_SQ * SQ_W;

  localparam int OCC_BIT  = 0;
  localparam int COL_BIT  = 1;
  localparam int TYPE_LSB = 2;

  localparam logic [2:0] PT_NONE   = 3'd0;
  localparam logic [2:0] PT_PAWN   = 3'd1;
  localparam logic [2:0] PT_KNIGHT = 3'd2;
  localparam logic [2:0] PT_BISHOP = 3'd3;
  localparam logic [2:0] PT_ROOK   = 3'd4;
  localparam logic [2:0] PT_QUEEN  = 3'd5;
  localparam logic [2:0] PT_KING   = 3'd6;

  localparam logic [SQ_W-1:0] EMPTY_SQ = 5'b00000;

  typedef enum logic [2:0] {
    RSP_OK           = 3'd0,
    RSP_EMPTY_SRC    = 3'd1,
    RSP_WRONG_COLOUR = 3'd2,
    RSP_OWN_DST      = 3'd3,
    RSP_NULL_MOVE    = 3'd4,
    RSP_GAME_OVER    = 3'd5
  } rsp_code_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_WRITE,
    ST_DONE
  } state_e;

  function automatic logic [SQ_W-1:0] make_sq(input logic [2:0] pt, input logic black);
    return {pt, black, 1'b1};
  endfunction

  function automatic logic [8:0] sq_lsb(input logic [2:0] r, input logic [2:0] c);
    return {3'b000, r, c} * 9'd5;
  endfunction

  function automatic logic [2:0] back_rank(input int c);
    case (c)
      1, 6:    return PT_KNIGHT;
      2, 5:    return PT_BISHOP;
      3:       return PT_QUEEN;
      4:       return PT_KING;
      default: return PT_ROOK;
    endcase
  endfunction

  function automatic logic [BOARD_W-1:0] init_board();
    logic [BOARD_W-1:0] b;
    b = '0;
    for (int c = 0; c < 8; c++) begin
      b[c * SQ_W +: SQ_W]        = make_sq(back_rank(c), 1'b1);
      b[(8 + c) * SQ_W +: SQ_W]  = make_sq(PT_PAWN, 1'b1);
      b[(48 + c) * SQ_W +: SQ_W] = make_sq(PT_PAWN, 1'b0);
      b[(56 + c) * SQ_W +: SQ_W] = make_sq(back_rank(c), 1'b0);
    end
    return b;
  endfunction

endpackage

// File: rtl/chess_board_update_move_check.sv
// Combinational move screening: rejection code by priority, capture type, and the
// square that lands on the destination (promotion resolved). Zero latency, no handshake.
module move_check
  import chess_pkg::*;
(
  input  logic [SQ_W-1:0] src_sq_i,
  input  logic [SQ_W-1:0] dst_sq_i,
  input  logic            turn_i,
  input  logic            game_over_i,
  input  logic [2:0]      from_row_i,
  input  logic [2:0]      from_col_i,
  input  logic [2:0]      to_row_i,
  input  logic [2:0]      to_col_i,
  input  logic [2:0]      promo_i,
  output logic [2:0]      code_o,
  output logic [2:0]      capt_o,
  output logic [SQ_W-1:0] moved_sq_o
);

  logic       same_sq;
  logic       promote;
  logic [2:0] promo_type;

  assign same_sq = ({from_row_i, from_col_i} == {to_row_i, to_col_i});

  always_comb begin
    code_o = RSP_OK;
    capt_o = PT_NONE;
    if (game_over_i) begin
      code_o = RSP_GAME_OVER;
    end else if (same_sq) begin
      code_o = RSP_NULL_MOVE;
    end else if (!src_sq_i[OCC_BIT]) begin
      code_o = RSP_EMPTY_SRC;
    end else if (src_sq_i[COL_BIT] != turn_i) begin
      code_o = RSP_WRONG_COLOUR;
    end else if (dst_sq_i[OCC_BIT] && (dst_sq_i[COL_BIT] == src_sq_i[COL_BIT])) begin
      code_o = RSP_OWN_DST;
    end else if (dst_sq_i[OCC_BIT]) begin
      capt_o = dst_sq_i[TYPE_LSB +: 3];
    end
  end

  // Pawns promote on the far rank of their own colour; out-of-range requests become a queen.
  assign promote = (src_sq_i[TYPE_LSB +: 3] == PT_PAWN) &&
                   ((!src_sq_i[COL_BIT] && (to_row_i == 3'd0)) ||
                    ( src_sq_i[COL_BIT] && (to_row_i == 3'd7)));
  assign promo_type = ((promo_i >= PT_KNIGHT) && (promo_i <= PT_QUEEN)) ? promo_i : PT_QUEEN;
  assign moved_sq_o = promote ? {promo_type, src_sq_i[COL_BIT:0]} : src_sq_i;

endmodule

// File: rtl/chess_board_update.sv
// Single writer of the 8x8 board: one move per handshake, response 3 cycles (ok) or
// 2 cycles (reject) after acceptance; mv_ready is low outside IDLE and when new_game is high.
module chess_board_update
  import chess_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               new_game,
  input  logic               mv_valid,
  output logic               mv_ready,
  input  logic [2:0]         from_row,
  input  logic [2:0]         from_col,
  input  logic [2:0]         to_row,
  input  logic [2:0]         to_col,
  input  logic [2:0]         promo,
  output logic               rsp_valid,
  output logic [2:0]         rsp_code,
  output logic [2:0]         rsp_capt,
  output logic               turn,
  output logic               game_over,
  output logic [BOARD_W-1:0] board_flat,
  input  logic [2:0]         rd_row,
  input  logic [2:0]         rd_col,
  output logic [SQ_W-1:0]    rd_sq
);

  state_e             state_q, state_d;
  logic [BOARD_W-1:0] board_q, board_d;
  logic               turn_q, turn_d;
  logic               game_over_q, game_over_d;
  logic [2:0]         rsp_code_q, rsp_code_d;
  logic [2:0]         rsp_capt_q, rsp_capt_d;
  logic [2:0]         from_row_q, from_row_d;
  logic [2:0]         from_col_q, from_col_d;
  logic [2:0]         to_row_q, to_row_d;
  logic [2:0]         to_col_q, to_col_d;
  logic [2:0]         promo_q, promo_d;
  logic [SQ_W-1:0]    rd_sq_q;

  logic [8:0]         from_lsb, to_lsb, rd_lsb;
  logic [SQ_W-1:0]    src_sq, dst_sq, moved_sq;
  logic [2:0]         chk_code, chk_capt;

  assign from_lsb = sq_lsb(from_row_q, from_col_q);
  assign to_lsb   = sq_lsb(to_row_q, to_col_q);
  assign rd_lsb   = sq_lsb(rd_row, rd_col);
  assign src_sq   = board_q[from_lsb +: SQ_W];
  assign dst_sq   = board_q[to_lsb +: SQ_W];

  // Board, turn and game_over are stable through CHECK and WRITE, so the
  // check result is still valid when WRITE commits it.
  move_check u_move_check (
    .src_sq_i    (src_sq),
    .dst_sq_i    (dst_sq),
    .turn_i      (turn_q),
    .game_over_i (game_over_q),
    .from_row_i  (from_row_q),
    .from_col_i  (from_col_q),
    .to_row_i    (to_row_q),
    .to_col_i    (to_col_q),
    .promo_i     (promo_q),
    .code_o      (chk_code),
    .capt_o      (chk_capt),
    .moved_sq_o  (moved_sq)
  );

  always_comb begin
    state_d     = state_q;
    board_d     = board_q;
    turn_d      = turn_q;
    game_over_d = game_over_q;
    rsp_code_d  = rsp_code_q;
    rsp_capt_d  = rsp_capt_q;
    from_row_d  = from_row_q;
    from_col_d  = from_col_q;
    to_row_d    = to_row_q;
    to_col_d    = to_col_q;
    promo_d     = promo_q;
    mv_ready    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        mv_ready = !new_game;
        if (new_game) begin
          board_d     = init_board();
          turn_d      = 1'b0;
          game_over_d = 1'b0;
          rsp_code_d  = RSP_OK;
          rsp_capt_d  = PT_NONE;
        end else if (mv_valid) begin
          from_row_d = from_row;
          from_col_d = from_col;
          to_row_d   = to_row;
          to_col_d   = to_col;
          promo_d    = promo;
          state_d    = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (chk_code == RSP_OK) begin
          state_d = ST_WRITE;
        end else begin
          rsp_code_d = chk_code;
          rsp_capt_d = PT_NONE;
          state_d    = ST_DONE;
        end
      end
      ST_WRITE: begin
        board_d[to_lsb +: SQ_W]   = moved_sq;
        board_d[from_lsb +: SQ_W] = EMPTY_SQ;
        turn_d                    = ~turn_q;
        if (chk_capt == PT_KING) begin
          game_over_d = 1'b1;
        end
        rsp_code_d = RSP_OK;
        rsp_capt_d = chk_capt;
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      board_q     <= init_board();
      turn_q      <= 1'b0;
      game_over_q <= 1'b0;
      rsp_code_q  <= RSP_OK;
      rsp_capt_q  <= PT_NONE;
      from_row_q  <= 3'd0;
      from_col_q  <= 3'd0;
      to_row_q    <= 3'd0;
      to_col_q    <= 3'd0;
      promo_q     <= 3'd0;
      rd_sq_q     <= EMPTY_SQ;
    end else begin
      state_q     <= state_d;
      board_q     <= board_d;
      turn_q      <= turn_d;
      game_over_q <= game_over_d;
      rsp_code_q  <= rsp_code_d;
      rsp_capt_q  <= rsp_capt_d;
      from_row_q  <= from_row_d;
      from_col_q  <= from_col_d;
      to_row_q    <= to_row_d;
      to_col_q    <= to_col_d;
      promo_q     <= promo_d;
      rd_sq_q     <= board_q[rd_lsb +: SQ_W];
    end
  end

  assign rsp_valid  = (state_q == ST_DONE);
  assign rsp_code   = rsp_code_q;
  assign rsp_capt   = rsp_capt_q;
  assign turn       = turn_q;
  assign game_over  = game_over_q;
  assign board_flat = board_q;
  assign rd_sq      = rd_sq_q;

endmodule

// File: tb/tb_chess_board_update.sv
// Directed and randomized bench for chess_board_update against a piece-level board model.
module tb_chess_board_update;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         new_game = 1'b0;
  logic         mv_valid = 1'b0;
  logic [2:0]   from_row = 3'd0, from_col = 3'd0, to_row = 3'd0, to_col = 3'd0, promo = 3'd0;
  logic [2:0]   rd_row = 3'd0, rd_col = 3'd0;
  logic         mv_ready, rsp_valid, turn, game_over;
  logic [2:0]   rsp_code, rsp_capt;
  logic [319:0] board_flat;
  logic [4:0]   rd_sq;

  int checks = 0;
  int passed = 0;

  // Model: per-square occupancy, colour and piece type as plain integers.
  int mtype  [8][8];
  bit mocc   [8][8];
  bit mblack [8][8];
  bit mturn;
  bit mover;

  chess_board_update dut (
    .clk        (clk),
    .reset      (reset),
    .new_game   (new_game),
    .mv_valid   (mv_valid),
    .mv_ready   (mv_ready),
    .from_row   (from_row),
    .from_col   (from_col),
    .to_row     (to_row),
    .to_col     (to_col),
    .promo      (promo),
    .rsp_valid  (rsp_valid),
    .rsp_code   (rsp_code),
    .rsp_capt   (rsp_capt),
    .turn       (turn),
    .game_over  (game_over),
    .board_flat (board_flat),
    .rd_row     (rd_row),
    .rd_col     (rd_col),
    .rd_sq      (rd_sq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks = checks + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_init();
    int back [8];
    back = '{4, 2, 3, 5, 6, 3, 2, 4};
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        mocc[r][c] = 1'b0; mblack[r][c] = 1'b0; mtype[r][c] = 0;
      end
    end
    for (int c = 0; c < 8; c++) begin
      mocc[0][c] = 1; mblack[0][c] = 1; mtype[0][c] = back[c];
      mocc[1][c] = 1; mblack[1][c] = 1; mtype[1][c] = 1;
      mocc[6][c] = 1; mblack[6][c] = 0; mtype[6][c] = 1;
      mocc[7][c] = 1; mblack[7][c] = 0; mtype[7][c] = back[c];
    end
    mturn = 0;
    mover = 0;
  endtask

  function automatic logic [4:0] enc(input int r, input int c);
    if (!mocc[r][c]) return 5'b00000;
    return {3'(mtype[r][c]), mblack[r][c], 1'b1};
  endfunction

  function automatic logic [319:0] model_flat();
    logic [319:0] f;
    f = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        f[(r * 8 + c) * 5 +: 5] = enc(r, c);
    return f;
  endfunction

  task automatic model_move(input int fr, input int fc, input int tr, input int tc, input int pr,
                            output int code, output int capt);
    int t;
    code = 0;
    capt = 0;
    if (mover) code = 5;
    else if (fr == tr && fc == tc) code = 4;
    else if (!mocc[fr][fc]) code = 1;
    else if (mblack[fr][fc] != mturn) code = 2;
    else if (mocc[tr][tc] && mblack[tr][tc] == mblack[fr][fc]) code = 3;
    if (code == 0) begin
      if (mocc[tr][tc]) capt = mtype[tr][tc];
      if (capt == 6) mover = 1;
      t = mtype[fr][fc];
      if (t == 1 && tr == (mblack[fr][fc] ? 7 : 0)) t = (pr >= 2 && pr <= 5) ? pr : 5;
      mocc[tr][tc] = 1; mblack[tr][tc] = mblack[fr][fc]; mtype[tr][tc] = t;
      mocc[fr][fc] = 0; mblack[fr][fc] = 0; mtype[fr][fc] = 0;
      mturn = !mturn;
    end
  endtask

  task automatic do_move(input int fr, input int fc, input int tr, input int tc, input int pr,
                         input string tag);
    int ecode, ecapt, lat, elat, w;
    logic [4:0] pre_dst;
    @(negedge clk);
    w = 0;
    while (mv_ready !== 1'b1 && w < 10) begin @(negedge clk); w++; end
    check({tag, " ready"}, 320'(mv_ready), 320'(1));
    pre_dst  = enc(tr, tc);
    from_row = 3'(fr); from_col = 3'(fc); to_row = 3'(tr); to_col = 3'(tc); promo = 3'(pr);
    rd_row   = 3'(tr); rd_col = 3'(tc);
    mv_valid = 1'b1;
    model_move(fr, fc, tr, tc, pr, ecode, ecapt);
    elat = (ecode == 0) ? 3 : 2;
    @(posedge clk);
    #1 mv_valid = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (rsp_valid === 1'b1) break;
    end
    check({tag, " latency"}, 320'(lat), 320'(elat));
    check({tag, " code"}, 320'(rsp_code), 320'(ecode));
    check({tag, " capt"}, 320'(rsp_capt), 320'(ecapt));
    check({tag, " board"}, board_flat, model_flat());
    check({tag, " turn"}, 320'(turn), 320'(mturn));
    check({tag, " game_over"}, 320'(game_over), 320'(mover));
    check({tag, " rd_pre"}, 320'(rd_sq), 320'(pre_dst));
    @(negedge clk);
    check({tag, " rsp_pulse"}, 320'(rsp_valid), 320'(0));
    check({tag, " ready_after"}, 320'(mv_ready), 320'(1));
    check({tag, " code_hold"}, 320'(rsp_code), 320'(ecode));
    check({tag, " rd_post"}, 320'(rd_sq), 320'(enc(tr, tc)));
  endtask

  task automatic do_new_game();
    logic seen;
    @(negedge clk);
    new_game = 1'b1; mv_valid = 1'b1;
    from_row = 3'd6; from_col = 3'd4; to_row = 3'd4; to_col = 3'd4; promo = 3'd0;
    #1 check("ng ready_low", 320'(mv_ready), 320'(0));
    @(posedge clk);
    #1 new_game = 1'b0; mv_valid = 1'b0;
    model_init();
    @(negedge clk);
    check("ng board", board_flat, model_flat());
    check("ng turn", 320'(turn), 320'(0));
    check("ng game_over", 320'(game_over), 320'(0));
    check("ng code", 320'(rsp_code), 320'(0));
    check("ng capt", 320'(rsp_capt), 320'(0));
    check("ng ready", 320'(mv_ready), 320'(1));
    seen = 1'b0;
    repeat (4) begin @(negedge clk); seen = seen | rsp_valid; end
    check("ng no_rsp", 320'(seen), 320'(0));
  endtask

  task automatic reset_during_write();
    logic seen;
    @(negedge clk);
    from_row = 3'd6; from_col = 3'd4; to_row = 3'd4; to_col = 3'd4; promo = 3'd0;
    mv_valid = 1'b1;
    @(posedge clk);
    #1 mv_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    model_init();
    @(negedge clk);
    check("rst board", board_flat, model_flat());
    check("rst rsp_valid", 320'(rsp_valid), 320'(0));
    check("rst ready", 320'(mv_ready), 320'(1));
    check("rst turn", 320'(turn), 320'(0));
    reset = 1'b0;
    @(posedge clk);
    #1 check("rst ready_first", 320'(mv_ready), 320'(1));
    seen = 1'b0;
    repeat (4) begin @(negedge clk); seen = seen | rsp_valid; end
    check("rst no_rsp", 320'(seen), 320'(0));
    check("rst board_after", board_flat, model_flat());
  endtask

  initial begin
    int fr, fc, tr, tc, tries;
    model_init();
    repeat (2) @(negedge clk);
    check("reset ready", 320'(mv_ready), 320'(1));
    check("reset rsp_valid", 320'(rsp_valid), 320'(0));
    check("reset code", 320'(rsp_code), 320'(0));
    check("reset capt", 320'(rsp_capt), 320'(0));
    check("reset turn", 320'(turn), 320'(0));
    check("reset game_over", 320'(game_over), 320'(0));
    check("reset board", board_flat, model_flat());
    check("reset rd_sq", 320'(rd_sq), 320'(0));
    reset = 1'b0;

    do_move(6, 4, 4, 4, 0, "e2e4");
    check("e4 square", 320'(board_flat[(4 * 8 + 4) * 5 +: 5]), 320'(5'b00101));
    do_move(6, 3, 5, 3, 0, "white_twice");
    do_move(3, 3, 2, 3, 0, "empty_src");
    do_move(7, 0, 7, 0, 0, "null_move");
    do_move(1, 4, 3, 4, 0, "black_e5");
    do_move(7, 0, 6, 0, 0, "own_dst");
    do_move(6, 0, 1, 0, 0, "pawn_to_row1");
    do_move(0, 0, 2, 1, 0, "clear_a8");
    do_move(1, 0, 0, 0, 3, "promo_bishop");
    check("promo bishop sq", 320'(board_flat[0 +: 5]), 320'(5'b01101));
    do_move(0, 1, 2, 2, 0, "clear_b8");
    do_move(6, 1, 1, 1, 0, "pawn2_to_row1");
    do_move(2, 2, 3, 2, 0, "black_wait");
    do_move(1, 1, 0, 1, 7, "promo_default");
    check("promo queen sq", 320'(board_flat[5 +: 5]), 320'(5'b10101));
    do_move(1, 7, 2, 7, 0, "black_wait2");
    do_move(0, 1, 0, 4, 0, "king_capture");
    do_move(2, 7, 3, 7, 0, "after_over");
    do_move(3, 3, 3, 3, 0, "null_after_over");
    do_new_game();
    reset_during_write();

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rd_row = 3'($urandom_range(0, 7));
      rd_col = 3'($urandom_range(0, 7));
      @(negedge clk);
      check("rd random", 320'(rd_sq), 320'(enc(int'(rd_row), int'(rd_col))));
    end

    for (int i = 0; i < 80; i++) begin
      if (mover && $urandom_range(0, 1) == 0) begin
        do_new_game();
      end else begin
        fr = $urandom_range(0, 7); fc = $urandom_range(0, 7);
        if ($urandom_range(0, 9) < 7) begin
          tries = 0;
          while (!(mocc[fr][fc] && mblack[fr][fc] == mturn) && tries < 64) begin
            fr = $urandom_range(0, 7); fc = $urandom_range(0, 7); tries++;
          end
        end
        tr = $urandom_range(0, 7); tc = $urandom_range(0, 7);
        do_move(fr, fc, tr, tc, $urandom_range(0, 7), "rand");
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
